sram_1w1r_port_ctrl: RTL
========================

Name: sram_1w1r_port_ctrl

Overview:
- Controller directly upstream and downstream of the 512x41 1W1R SRAM macro.
- Converts valid/ready write and read requests into macro port-0 and port-1 strobes.
- Captures macro read data and returns it through a backpressurable response interface.
- Resolves same-cycle write/read address conflicts so the macro never sees a simultaneous write and read to the same address.

Parameters:
- ADDR_WIDTH, 9, word address width (depth 512)
- DATA_WIDTH, 41, stored word width (40 data bits plus 1 spare bit at MSB)
- NUM_WMASKS, 5, byte write-enable count covering bits [39:0]
- RESP_DEPTH, 2, response buffer entries (in-flight plus buffered reads); min 2

Ports:
- clk_i  in  1  single clock for controller and both macro ports
- rst_i  in  1  synchronous, active-high reset
- wr_valid_i  in  1  write request valid
- wr_ready_o  out  1  write request accepted when valid&ready
- wr_addr_i  in  ADDR_WIDTH  write word address
- wr_data_i  in  DATA_WIDTH  write data
- wr_mask_i  in  NUM_WMASKS  byte enables for bits [39:0]
- wr_spare_en_i  in  1  write enable for spare bit 40
- rd_valid_i  in  1  read request valid
- rd_ready_o  out  1  read request accepted when valid&ready
- rd_addr_i  in  ADDR_WIDTH  read word address
- rsp_valid_o  out  1  read response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_data_o  out  DATA_WIDTH  read response data
- sram_csb0_o  out  1  macro port-0 chip select, active low
- sram_wmask0_o  out  NUM_WMASKS  macro byte mask
- sram_spare_wen0_o  out  1  macro spare bit write enable
- sram_addr0_o  out  ADDR_WIDTH  macro write address
- sram_din0_o  out  DATA_WIDTH  macro write data
- sram_csb1_o  out  1  macro port-1 chip select, active low
- sram_addr1_o  out  ADDR_WIDTH  macro read address
- sram_dout1_i  in  DATA_WIDTH  macro read data

Behaviour:
- **Reset.** One clock; rst_i is synchronous and active-high. While rst_i=1:
  - wr_ready_o=0, rd_ready_o=0, rsp_valid_o=0, rsp_data_o=0.
  - sram_csb0_o=1, sram_csb1_o=1; all other sram_* outputs 0.
  - In-flight reads and buffered responses are discarded; occupancy counter is cleared to 0.
- **SRAM port drive.** Macro port signals are combinational from the accepted request in the same cycle. The macro registers them at the closing edge.
  - sram_csb0_o = !(wr_valid_i & wr_ready_o).
  - sram_csb1_o = !(rd_valid_i & rd_ready_o).
  - When csb is high, address/data/mask outputs are don't-care but must not be X; drive 0.
- **Writes.**
  - wr_ready_o=1 every cycle out of reset. A write is never stalled.
  - Mask and spare enable pass straight to the macro. A write with wr_mask_i=0 and wr_spare_en_i=0 still asserts csb0 and modifies nothing.
- **Reads.**
  - A read accepted in cycle N has its data valid on sram_dout1_i during the second half of cycle N+1.
  - It is captured into the response FIFO at the end of N+1. rsp_valid_o can first assert in N+2 (latency 2).
  - sram_dout1_i is sampled only in the cycle following an accepted read; other cycles ignore it (it may be X).
- **Credits.**
  - occ = reads in flight + entries held in FIFO; occ never exceeds RESP_DEPTH.
  - rd_ready_o = (occ < RESP_DEPTH) & !conflict. A response popped (rsp_valid_o & rsp_ready_i) in the same cycle frees a credit in that same cycle.
  - Back-to-back reads sustain 1 per cycle when rsp_ready_i=1 and RESP_DEPTH>=2.
- **Responses.**
  - Strictly in request order.
  - rsp_data_o is held stable while rsp_valid_o=1 & rsp_ready_i=0.
- **Conflict.**
  - conflict = wr_valid_i & rd_valid_i & (wr_addr_i == rd_addr_i).
  - The write proceeds and the read is stalled (rd_ready_o=0) that cycle.
  - The read is accepted the next cycle if still presented, and returns the newly written data.
  - A read to the same address in the cycle after a write needs no stall and returns the new data.
- **Simultaneous write and read to different addresses:** both are accepted in the same cycle.

Test Plan:
- Reset then idle: hold rst_i=1 for 3 cycles with requests asserted -> csb0=csb1=1, rd_ready_o=0, rsp_valid_o=0; after release wr_ready_o=1 and rd_ready_o=1.
- Full write then read:
  - write addr 0x005, data 0x1_AABBCCDDEE, mask 5'b11111, spare_en 1;
  - read 0x005 two cycles later;
  - -> rsp_valid_o asserts exactly 2 cycles after read acceptance with rsp_data_o=0x1_AABBCCDDEE.
- Byte mask:
  - write 0x010 with 0x0_1122334455 (full mask);
  - then write 0x0_FFFFFFFFFF with mask 5'b00101, spare_en 0;
  - read 0x010 -> 0x0_1122FF44FF.
- Conflict: same-cycle write 0x1FF data 0x0_0000000077 and read 0x1FF -> rd_ready_o=0 that cycle; read accepted next cycle; response 0x0_0000000077.
- Backpressure:
  - rsp_ready_i=0, issue reads to 0x001..0x004 back-to-back -> only 2 accepted, rd_ready_o=0 thereafter;
  - raise rsp_ready_i -> responses for 0x001, 0x002, 0x003, 0x004 in order, none lost or duplicated.
- Reset mid-operation: two reads in flight, assert rst_i for 1 cycle -> no rsp_valid_o afterwards for those reads; occ returns to 0 (rd_ready_o=1 next cycle).

Source files
------------

// File: rtl/sram_1w1r_port_ctrl_if.sv
// ----------------------------------------------------------------------------
// sram_1w1r_port_ctrl_if: write/read request and read response bus. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sram_1w1r_port_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 41,
  parameter int NUM_WMASKS = 5
);
  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic [ADDR_WIDTH-1:0] wr_addr_i;
  logic [DATA_WIDTH-1:0] wr_data_i;
  logic [NUM_WMASKS-1:0] wr_mask_i;
  logic                  wr_spare_en_i;
  logic                  rd_valid_i;
  logic                  rd_ready_o;
  logic [ADDR_WIDTH-1:0] rd_addr_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_data_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i, wr_spare_en_i,
    output rd_valid_i, rd_addr_i, rsp_ready_i,
    input  wr_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i, wr_spare_en_i,
    input  rd_valid_i, rd_addr_i, rsp_ready_i,
    output wr_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o
  );
endinterface

`default_nettype wire

// File: rtl/sram_1w1r_port_ctrl.sv
// ----------------------------------------------------------------------------
// sram_1w1r_port_ctrl: valid/ready front end for a 1W1R SRAM macro. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_1w1r_port_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 41,
  parameter int NUM_WMASKS = 5,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sram_1w1r_port_ctrl_if.slave  bus,
  output logic                  sram_csb0_o,
  output logic [NUM_WMASKS-1:0] sram_wmask0_o,
  output logic                  sram_spare_wen0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  output logic                  sram_csb1_o,
  output logic [ADDR_WIDTH-1:0] sram_addr1_o,
  input  logic [DATA_WIDTH-1:0] sram_dout1_i
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RESP_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  conflict;
  logic                  pop;
  logic [OCC_W-1:0]      occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A read only gets a credit if its response slot is guaranteed; a pop in
  // the same cycle releases one slot immediately.
  always_comb begin
    conflict         = bus.wr_valid_i & bus.rd_valid_i & (bus.wr_addr_i == bus.rd_addr_i);
    occ              = OCC_W'(cnt_q) + OCC_W'(inflight_q);
    bus.rsp_valid_o  = !rst_i & (cnt_q != '0);
    bus.rsp_data_o   = bus.rsp_valid_o ? mem_q[rptr_q] : '0;
    pop              = bus.rsp_valid_o & bus.rsp_ready_i;
    bus.wr_ready_o   = !rst_i;
    bus.rd_ready_o   = !rst_i & !conflict & ((occ < OCC_W'(RESP_DEPTH)) | pop);
    wr_acc           = bus.wr_valid_i & bus.wr_ready_o;
    rd_acc           = bus.rd_valid_i & bus.rd_ready_o;
  end

  always_comb begin
    sram_csb0_o       = !wr_acc;
    sram_wmask0_o     = wr_acc ? bus.wr_mask_i     : '0;
    sram_spare_wen0_o = wr_acc & bus.wr_spare_en_i;
    sram_addr0_o      = wr_acc ? bus.wr_addr_i     : '0;
    sram_din0_o       = wr_acc ? bus.wr_data_i     : '0;
    sram_csb1_o       = !rd_acc;
    sram_addr1_o      = rd_acc ? bus.rd_addr_i     : '0;
  end

  // Macro read data is only trusted in the cycle after an accepted read.
  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    inflight_d = rd_acc;
    cnt_d      = cnt_q + CNT_W'(inflight_q) - CNT_W'(pop);
    if (inflight_q) begin
      mem_d[wptr_q] = sram_dout1_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire
